ysyx_24100006_csr_ctrl: RTL and testbench

YSYX_24100006_CSR_CTRL -- requirements
Module: ysyx_24100006_csr_ctrl

---
 rtl/ysyx_24100006_csr_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_ysyx_24100006_csr_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24100006_csr_ctrl.sv
// CSR / system-instruction sequencer.
// Walks each accepted instruction through IDLE -> READ -> WRITE -> RESP:
// it reads the addressed CSR, issues at most one write or trap strobe,
// then holds the result until the consumer takes it.
module ysyx_24100006_csr_ctrl #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_op,
  input  logic [2:0]            in_funct3,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_src,
  input  logic [4:0]            in_idx,
  input  logic [DATA_WIDTH-1:0] in_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_wen,
  output logic                  redirect,
  output logic [DATA_WIDTH-1:0] redirect_pc,
  output logic [ADDR_WIDTH-1:0] csr_raddr,
  input  logic [DATA_WIDTH-1:0] csr_rdata,
  output logic [ADDR_WIDTH-1:0] csr_waddr,
  output logic [DATA_WIDTH-1:0] csr_wdata,
  output logic                  csr_wen,
  output logic                  csr_irq,
  input  logic [DATA_WIDTH-1:0] mtvec,
  input  logic [DATA_WIDTH-1:0] mepc
);

  localparam logic [1:0] OP_CSR   = 2'b00;
  localparam logic [1:0] OP_ECALL = 2'b01;
  localparam logic [1:0] OP_MRET  = 2'b10;
  localparam logic [DATA_WIDTH-1:0] D_ZERO = {DATA_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] A_ZERO = {ADDR_WIDTH{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_READ  = 2'b01,
    S_WRITE = 2'b10,
    S_RESP  = 2'b11
  } state_t;

  state_t                r_state;
  logic [1:0]            r_op;
  logic [2:0]            r_funct3;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_src;
  logic [4:0]            r_idx;
  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_old;
  logic [DATA_WIDTH-1:0] r_target;

  logic                  r_in_ready;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_wen;
  logic                  r_redirect;
  logic [DATA_WIDTH-1:0] r_redirect_pc;
  logic [DATA_WIDTH-1:0] r_csr_wdata;
  logic                  r_csr_wen;
  logic                  r_csr_irq;

  logic [DATA_WIDTH-1:0] w_operand;
  logic [DATA_WIDTH-1:0] w_new;
  logic                  w_is_csr;
  logic                  w_csr_wen;
  logic                  w_is_ecall;
  logic                  w_is_mret;

  // Decode the captured instruction and form the candidate new CSR value from the live read data.
  always_comb begin
    w_operand  = r_funct3[2] ? {{(DATA_WIDTH-5){1'b0}}, r_idx} : r_src;
    w_new      = D_ZERO;
    w_is_csr   = (r_op == OP_CSR) && (r_funct3[1:0] != 2'b00);
    w_is_ecall = (r_op == OP_ECALL);
    w_is_mret  = (r_op == OP_MRET);
    case (r_funct3[1:0])
      2'b01:   w_new = w_operand;
      2'b10:   w_new = csr_rdata | w_operand;
      2'b11:   w_new = csr_rdata & ~w_operand;
      default: w_new = D_ZERO;
    endcase
    // Set/clear with x0 / zimm 0 is a pure read; plain write always writes.
    if (w_is_csr) begin
      w_csr_wen = (r_funct3[1:0] == 2'b01) || (r_idx != 5'd0);
    end else begin
      w_csr_wen = 1'b0;
    end
  end

  // Sequencer state plus every registered output, advanced one phase per cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_op          <= 2'b00;
      r_funct3      <= 3'b000;
      r_addr        <= A_ZERO;
      r_src         <= D_ZERO;
      r_idx         <= 5'd0;
      r_pc          <= D_ZERO;
      r_old         <= D_ZERO;
      r_target      <= D_ZERO;
      r_in_ready    <= 1'b1;
      r_out_valid   <= 1'b0;
      r_rd_data     <= D_ZERO;
      r_rd_wen      <= 1'b0;
      r_redirect    <= 1'b0;
      r_redirect_pc <= D_ZERO;
      r_csr_wdata   <= D_ZERO;
      r_csr_wen     <= 1'b0;
      r_csr_irq     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_op       <= in_op;
            r_funct3   <= in_funct3;
            r_addr     <= in_addr;
            r_src      <= in_src;
            r_idx      <= in_idx;
            r_pc       <= in_pc;
            r_in_ready <= 1'b0;
            r_state    <= S_READ;
          end else begin
            r_state    <= S_IDLE;
          end
        end
        S_READ: begin
          // Sample old value and trap/return vectors now; strobes go out for exactly the WRITE cycle.
          r_old       <= csr_rdata;
          r_target    <= w_is_ecall ? mtvec : (w_is_mret ? mepc : D_ZERO);
          r_csr_wdata <= w_is_ecall ? r_pc : (w_csr_wen ? w_new : D_ZERO);
          r_csr_wen   <= w_csr_wen;
          r_csr_irq   <= w_is_ecall;
          r_state     <= S_WRITE;
        end
        S_WRITE: begin
          r_csr_wdata   <= D_ZERO;
          r_csr_wen     <= 1'b0;
          r_csr_irq     <= 1'b0;
          r_out_valid   <= 1'b1;
          r_rd_data     <= w_is_csr ? r_old : D_ZERO;
          r_rd_wen      <= w_is_csr;
          r_redirect    <= w_is_ecall || w_is_mret;
          r_redirect_pc <= r_target;
          r_state       <= S_RESP;
        end
        S_RESP: begin
          if (out_ready) begin
            r_out_valid   <= 1'b0;
            r_rd_data     <= D_ZERO;
            r_rd_wen      <= 1'b0;
            r_redirect    <= 1'b0;
            r_redirect_pc <= D_ZERO;
            r_in_ready    <= 1'b1;
            r_state       <= S_IDLE;
          end else begin
            r_state       <= S_RESP;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_csr_wen   <= 1'b0;
          r_csr_irq   <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign rd_data     = r_rd_data;
  assign rd_wen      = r_rd_wen;
  assign redirect    = r_redirect;
  assign redirect_pc = r_redirect_pc;
  assign csr_raddr   = r_addr;
  assign csr_waddr   = r_addr;
  assign csr_wdata   = r_csr_wdata;
  assign csr_wen     = r_csr_wen;
  assign csr_irq     = r_csr_irq;

endmodule

// File: tb/tb_ysyx_24100006_csr_ctrl.sv
// Self-checking bench for ysyx_24100006_csr_ctrl: a transaction-level model
// predicts every output each cycle, and directed vectors pin literal results.
module tb_ysyx_24100006_csr_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = 2'b00;
  logic [2:0]  in_funct3 = 3'b000;
  logic [11:0] in_addr = 12'h000;
  logic [31:0] in_src = 32'h0;
  logic [4:0]  in_idx = 5'd0;
  logic [31:0] in_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] rd_data;
  logic        rd_wen;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [11:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        csr_wen;
  logic        csr_irq;
  logic [31:0] mtvec = 32'h0;
  logic [31:0] mepc = 32'h0;

  // transaction setup as seen by the model (ports may be scrambled later)
  logic [11:0] t_addr = 12'h000;
  logic [31:0] t_old = 32'h0;
  logic [31:0] t_mtvec = 32'h0;
  logic [31:0] t_mepc = 32'h0;

  int n_vec = 0;
  int n_err = 0;
  int wen_cnt = 0;
  int irq_cnt = 0;

  // CSR file stand-in: only the intended address returns the prepared value
  assign csr_rdata = (csr_raddr == t_addr) ? t_old : 32'hDEADBEEF;

  always #5 clk = ~clk;

  ysyx_24100006_csr_ctrl #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_funct3(in_funct3), .in_addr(in_addr),
    .in_src(in_src), .in_idx(in_idx), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .rd_data(rd_data), .rd_wen(rd_wen),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .csr_raddr(csr_raddr), .csr_rdata(csr_rdata), .csr_waddr(csr_waddr),
    .csr_wdata(csr_wdata), .csr_wen(csr_wen), .csr_irq(csr_irq),
    .mtvec(mtvec), .mepc(mepc)
  );

  typedef struct packed {
    logic        wen;
    logic        irq;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic        rd_wen;
    logic        redir;
    logic [31:0] rpc;
  } exp_t;

  // Architectural effect of one instruction, straight from the instruction rules
  function automatic exp_t expect_fn(input logic [1:0] op, input logic [2:0] f3,
                                     input logic [31:0] src, input logic [4:0] idx,
                                     input logic [31:0] pc, input logic [31:0] old,
                                     input logic [31:0] tv, input logic [31:0] ep);
    exp_t e;
    logic [31:0] opnd;
    e = '0;
    opnd = f3[2] ? {27'd0, idx} : src;
    case (op)
      2'b00: begin
        case (f3)
          3'b001, 3'b101: begin e.wen = 1'b1; e.wdata = opnd; e.rd = old; e.rd_wen = 1'b1; end
          3'b010, 3'b110: begin e.wen = (idx != 5'd0); e.wdata = old | opnd; e.rd = old; e.rd_wen = 1'b1; end
          3'b011, 3'b111: begin e.wen = (idx != 5'd0); e.wdata = old & ~opnd; e.rd = old; e.rd_wen = 1'b1; end
          default: ;
        endcase
      end
      2'b01: begin e.irq = 1'b1; e.wdata = pc; e.redir = 1'b1; e.rpc = tv; end
      2'b10: begin e.redir = 1'b1; e.rpc = ep; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Protocol-level model: 0 idle, 1..2 in flight, 3 waiting for consumer
  int          m_phase = 0;
  logic [11:0] m_addr = 12'h000;
  exp_t        m_exp = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase <= 0;
      m_addr  <= 12'h000;
      m_exp   <= '0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
             m_phase <= 1;
             m_addr  <= in_addr;
             m_exp   <= expect_fn(in_op, in_funct3, in_src, in_idx, in_pc, t_old, t_mtvec, t_mepc);
           end
        1: m_phase <= 2;
        2: m_phase <= 3;
        3: if (out_ready) m_phase <= 0;
        default: m_phase <= 0;
      endcase
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (csr_wen) wen_cnt++;
    if (csr_irq) irq_cnt++;
    chk("in_ready", 32'(in_ready), 32'(m_phase == 0));
    chk("out_valid", 32'(out_valid), 32'(m_phase == 3));
    chk("csr_raddr", 32'(csr_raddr), 32'(m_addr));
    chk("csr_waddr", 32'(csr_waddr), 32'(m_addr));
    chk("csr_wen", 32'(csr_wen), 32'((m_phase == 2) && m_exp.wen));
    chk("csr_irq", 32'(csr_irq), 32'((m_phase == 2) && m_exp.irq));
    if (m_phase != 2) chk("csr_wdata_idle", csr_wdata, 32'h0);
    else if (m_exp.wen || m_exp.irq) chk("csr_wdata", csr_wdata, m_exp.wdata);
    chk("rd_wen", 32'(rd_wen), 32'((m_phase == 3) && m_exp.rd_wen));
    chk("redirect", 32'(redirect), 32'((m_phase == 3) && m_exp.redir));
    if (m_phase != 3) begin
      chk("rd_data_idle", rd_data, 32'h0);
      chk("redirect_pc_idle", redirect_pc, 32'h0);
    end else begin
      if (m_exp.rd_wen) chk("rd_data", rd_data, m_exp.rd);
      if (m_exp.redir) chk("redirect_pc", redirect_pc, m_exp.rpc);
    end
  end

  // snapshots taken inside a transaction for literal checks
  logic        s_wen, s_irq, s_rdwen, s_redir;
  logic [31:0] s_wdata, s_rd, s_rpc;
  logic [11:0] s_waddr;
  int          w0, i0;

  // One full instruction; called at posedge+1 with the DUT idle
  task automatic run_op(input logic [1:0] op, input logic [2:0] f3, input logic [11:0] addr,
                        input logic [31:0] src, input logic [4:0] idx, input logic [31:0] pc,
                        input logic [31:0] old, input logic [31:0] tv, input logic [31:0] ep,
                        input int hold);
    t_addr = addr; t_old = old; t_mtvec = tv; t_mepc = ep;
    mtvec = tv; mepc = ep;
    in_op = op; in_funct3 = f3; in_addr = addr; in_src = src; in_idx = idx; in_pc = pc;
    out_ready = (hold == 0);
    w0 = wen_cnt; i0 = irq_cnt;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_op = ~op; in_funct3 = ~f3; in_addr = ~addr; in_src = ~src; in_idx = ~idx; in_pc = ~pc;
    @(posedge clk); #1;
    s_wen = csr_wen; s_irq = csr_irq; s_wdata = csr_wdata; s_waddr = csr_waddr;
    mtvec = ~tv; mepc = ~ep;
    @(posedge clk); #1;
    chk("latency_out_valid", 32'(out_valid), 32'h1);
    s_rd = rd_data; s_rdwen = rd_wen; s_redir = redirect; s_rpc = redirect_pc;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("resp_done_in_ready", 32'(in_ready), 32'h1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_csr_wen", 32'(csr_wen), 32'h0);
    chk("rst_raddr", 32'(csr_raddr), 32'h0);
    reset = 1'b0;

    // CSRRW mtvec
    run_op(2'b00, 3'b001, 12'h305, 32'h80000100, 5'd5, 32'h0, 32'h0, 32'h0, 32'h0, 0);
    chk("rw_wen_pulses", 32'(wen_cnt - w0), 32'd1);
    chk("rw_waddr", 32'(s_waddr), 32'h305);
    chk("rw_wdata", s_wdata, 32'h80000100);
    chk("rw_rd", s_rd, 32'h0);
    chk("rw_rdwen", 32'(s_rdwen), 32'h1);
    chk("rw_addr_held", 32'(csr_raddr), 32'h305);

    // CSRRS x0: read only
    run_op(2'b00, 3'b010, 12'h300, 32'hFFFFFFFF, 5'd0, 32'h0, 32'h00001800, 32'h0, 32'h0, 0);
    chk("rs0_wen_pulses", 32'(wen_cnt - w0), 32'd0);
    chk("rs0_rd", s_rd, 32'h00001800);

    // CSRRCI zimm 3
    run_op(2'b00, 3'b111, 12'h341, 32'h0, 5'd3, 32'h0, 32'h8000000F, 32'h0, 32'h0, 0);
    chk("rci_wdata", s_wdata, 32'h8000000C);
    chk("rci_rd", s_rd, 32'h8000000F);
    chk("rci_wen_pulses", 32'(wen_cnt - w0), 32'd1);

    // ECALL then MRET
    run_op(2'b01, 3'b000, 12'h000, 32'h0, 5'd0, 32'h80000040, 32'h0, 32'h80000100, 32'h0, 0);
    chk("ecall_irq_pulses", 32'(irq_cnt - i0), 32'd1);
    chk("ecall_wen_pulses", 32'(wen_cnt - w0), 32'd0);
    chk("ecall_wdata", s_wdata, 32'h80000040);
    chk("ecall_rpc", s_rpc, 32'h80000100);
    chk("ecall_redir", 32'(s_redir), 32'h1);
    chk("ecall_rdwen", 32'(s_rdwen), 32'h0);
    run_op(2'b10, 3'b000, 12'h000, 32'h0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h80000040, 0);
    chk("mret_rpc", s_rpc, 32'h80000040);
    chk("mret_irq_pulses", 32'(irq_cnt - i0), 32'd0);
    chk("mret_wen_pulses", 32'(wen_cnt - w0), 32'd0);

    // CSRRS with backpressure for 5 cycles
    run_op(2'b00, 3'b010, 12'h300, 32'h00000008, 5'd2, 32'h0, 32'h00001800, 32'h0, 32'h0, 5);
    chk("bp_wdata", s_wdata, 32'h00001808);
    chk("bp_wen_pulses", 32'(wen_cnt - w0), 32'd1);
    chk("bp_rd", s_rd, 32'h00001800);

    // CSRRWI zimm 0 still writes; CSRRC register form
    run_op(2'b00, 3'b101, 12'h340, 32'hFFFFFFFF, 5'd0, 32'h0, 32'h12345678, 32'h0, 32'h0, 0);
    chk("rwi0_wen_pulses", 32'(wen_cnt - w0), 32'd1);
    chk("rwi0_wdata", s_wdata, 32'h0);
    run_op(2'b00, 3'b011, 12'h344, 32'h000000FF, 5'd7, 32'h0, 32'h0000F0F0, 32'h0, 32'h0, 0);
    chk("rc_wdata", s_wdata, 32'h0000F000);

    // funct3 000/100 and illegal op: handshake only
    run_op(2'b00, 3'b000, 12'h305, 32'h1, 5'd1, 32'h0, 32'h55, 32'h0, 32'h0, 0);
    chk("f0_rdwen", 32'(s_rdwen), 32'h0);
    chk("f0_wen_pulses", 32'(wen_cnt - w0), 32'd0);
    run_op(2'b00, 3'b100, 12'h305, 32'h1, 5'd1, 32'h0, 32'h55, 32'h0, 32'h0, 0);
    chk("f4_wen_pulses", 32'(wen_cnt - w0), 32'd0);
    run_op(2'b11, 3'b001, 12'h305, 32'h1, 5'd1, 32'h0, 32'h55, 32'h0, 32'h0, 0);
    chk("ill_wen_pulses", 32'(wen_cnt - w0), 32'd0);
    chk("ill_irq_pulses", 32'(irq_cnt - i0), 32'd0);
    chk("ill_redir", 32'(s_redir), 32'h0);

    // Reset while in READ aborts the instruction
    t_addr = 12'h123; t_old = 32'hA5A5A5A5;
    in_op = 2'b00; in_funct3 = 3'b001; in_addr = 12'h123; in_src = 32'h11111111; in_idx = 5'd1;
    w0 = wen_cnt; i0 = irq_cnt;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'h1);
    chk("midrst_raddr", 32'(csr_raddr), 32'h0);
    chk("midrst_wen", 32'(csr_wen), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_release_ready", 32'(in_ready), 32'h1);
    run_op(2'b00, 3'b001, 12'h305, 32'h80000200, 5'd5, 32'h0, 32'h80000100, 32'h0, 32'h0, 0);
    chk("after_rst_wen_pulses", 32'(wen_cnt - w0), 32'd1);
    chk("after_rst_wdata", s_wdata, 32'h80000200);
    chk("after_rst_rd", s_rd, 32'h80000100);

    repeat (2) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
